// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - shared types, defaults and helpers for the TRNG conditioner
//
// Purpose: corrector state encoding, default parameter values and the
// bit-count width helper used by trng_conditioner and bit_sync.
// Optional feature macro used by the block: TRNG_HEALTH_EN.
package trng_pkg;

    typedef enum logic {
        VN_IDLE = 1'b0,
        VN_HALF = 1'b1
    } vn_state_t;

    localparam int TRNG_SYNC_STAGES = 2;
    localparam int TRNG_SAMPLE_DIV  = 4;
    localparam int TRNG_WIDTH       = 8;
    localparam int TRNG_REP_LIMIT   = 32;

    // The bit count has to reach WIDTH itself (a full word that is waiting
    // for the output slot), so it needs one more code than WIDTH-1.
    function automatic int trng_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-flop synchroniser for one asynchronous bit
//
// Purpose: brings an asynchronous single-bit signal into the clk domain.
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset, clears the chain
//   d      in   asynchronous input bit
//   q      out  synchronised bit (last stage of the chain)
module bit_sync
    import trng_pkg::*;
#(
    parameter int STAGES = TRNG_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/trng_conditioner.sv
// rtl/trng_conditioner.sv - ring-oscillator bit to conditioned random words
//
// Purpose: synchronise rnd_raw, decimate it by SAMPLE_DIV, debias with a
// von Neumann corrector, pack into WIDTH-bit words and present them on a
// valid/ready output. Optional repetition-count health test when the
// macro TRNG_HEALTH_EN is defined; otherwise health_fail is tied low.
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   en           in   block enable; low synchronously clears the datapath
//   rnd_raw      in   raw ring-oscillator bit, asynchronous to clk
//   out_ready    in   consumer takes the word when out_valid && out_ready
//   out_valid    out  out_data holds an unconsumed word
//   out_data     out  conditioned random word, first emitted bit at MSB
//   health_fail  out  sticky health-test failure flag
module trng_conditioner
    import trng_pkg::*;
#(
    parameter int SYNC_STAGES = TRNG_SYNC_STAGES,
    parameter int SAMPLE_DIV  = TRNG_SAMPLE_DIV,
    parameter int WIDTH       = TRNG_WIDTH,
    parameter int REP_LIMIT   = TRNG_REP_LIMIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             rnd_raw,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             health_fail
);

    localparam int             CW       = trng_cnt_width(WIDTH);
    localparam logic [7:0]     DIV_LAST = 8'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    logic             samp_bit;
    logic [7:0]       div_cnt;
    logic             strobe;
    vn_state_t        vn_state;
    logic             first;
    logic             emit;
    logic             emit_bit;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [CW-1:0]    bit_cnt;
    logic             word_full;
    logic             slot_free;
    logic             health_block;
    logic             load_full;
    logic             load_direct;
    logic             load;
    logic [WIDTH-1:0] load_data;

    // The synchroniser is deliberately outside the en clear so that the
    // chain already holds valid samples when the block is re-enabled.
    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rnd_raw),
        .q     (samp_bit)
    );

    // Sample divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!en || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 8'd1;
        end
    end

    assign strobe = en && (div_cnt == DIV_LAST);

    // Von Neumann corrector: an unequal pair emits its first bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vn_state <= VN_IDLE;
            first    <= 1'b0;
        end else if (!en) begin
            vn_state <= VN_IDLE;
            first    <= 1'b0;
        end else if (strobe) begin
            case (vn_state)
                VN_IDLE: begin
                    first    <= samp_bit;
                    vn_state <= VN_HALF;
                end
                default: vn_state <= VN_IDLE;
            endcase
        end
    end

    assign emit     = strobe && (vn_state == VN_HALF) && (samp_bit != first);
    assign emit_bit = first;

`ifdef TRNG_HEALTH_EN
    localparam int            RW      = $clog2(REP_LIMIT + 1);
    localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);

    logic [RW-1:0] run_cnt;
    logic [RW-1:0] run_next;
    logic          prev_samp;
    logic          hf;

    // run_cnt == 0 means no sample seen since reset/enable.
    always_comb begin
        run_next = run_cnt;
        if (run_cnt == '0 || samp_bit != prev_samp) begin
            run_next = RW'(1);
        end else if (run_cnt != REP_MAX) begin
            run_next = run_cnt + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt   <= '0;
            prev_samp <= 1'b0;
            hf        <= 1'b0;
        end else if (!en) begin
            run_cnt   <= '0;
            prev_samp <= 1'b0;
            hf        <= 1'b0;
        end else if (strobe) begin
            run_cnt   <= run_next;
            prev_samp <= samp_bit;
            if (run_next == REP_MAX) begin
                hf <= 1'b1;
            end
        end
    end

    assign health_fail  = hf;
    assign health_block = hf;
`else
    // REP_LIMIT only matters when the repetition test is built in.
    logic unused_rep_limit;
    assign unused_rep_limit = ^REP_LIMIT;
    assign health_fail      = 1'b0;
    assign health_block     = 1'b0;
`endif

    // Word hand-off. A word completing on the current emit goes straight
    // to the output (one-cycle latency); a word that had to wait in the
    // shift register (bit_cnt == WIDTH) goes out as soon as the slot frees.
    assign shifted     = {shreg[WIDTH-2:0], emit_bit};
    assign word_full   = (bit_cnt == CNT_FULL);
    assign slot_free   = !out_valid || out_ready;
    assign load_full   = word_full && slot_free && !health_block;
    assign load_direct = !word_full && emit && (bit_cnt == CNT_LAST)
                         && slot_free && !health_block;
    assign load        = load_full || load_direct;
    assign load_data   = load_full ? shreg : shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (!en) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (load_full) begin
            // The waiting word leaves; a bit emitted in the same cycle
            // starts the next word instead of being lost.
            if (emit) begin
                shreg   <= shifted;
                bit_cnt <= CW'(1);
            end else begin
                bit_cnt <= '0;
            end
        end else if (word_full) begin
            // Full and blocked: drop new bits, never overwrite.
            bit_cnt <= bit_cnt;
        end else if (emit) begin
            shreg   <= shifted;
            bit_cnt <= load_direct ? '0 : bit_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (!en) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trng_conditioner.sv
// tb/tb_trng_conditioner.sv - self-checking bench for trng_conditioner
module tb_trng_conditioner;

    localparam logic HEALTH_ON =
`ifdef TRNG_HEALTH_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       rnd_raw;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       health_fail;

    logic       en4;
    logic       raw4;
    logic       ready4;
    logic       valid4;
    logic [7:0] data4;
    logic       hf4;

    trng_conditioner #(
        .SYNC_STAGES (2),
        .SAMPLE_DIV  (1),
        .WIDTH       (8),
        .REP_LIMIT   (32)
    ) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .rnd_raw     (rnd_raw),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .health_fail (health_fail)
    );

    trng_conditioner #(
        .SYNC_STAGES (2),
        .SAMPLE_DIV  (4),
        .WIDTH       (8),
        .REP_LIMIT   (32)
    ) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en4),
        .rnd_raw     (raw4),
        .out_ready   (ready4),
        .out_valid   (valid4),
        .out_data    (data4),
        .health_fail (hf4)
    );

    typedef struct {
        logic [63:0] bits;
        int          n;
        int          nw;
        logic [7:0]  w0;
        logic [7:0]  w1;
        int          rise;
    } vec_t;

    vec_t       vt [6];
    logic [7:0] exp_q [$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         c0 = 0;
    int         rise_cyc = -1;
    int         acc_cnt = 0;
    int         ph = 0;
    logic       p_hold = 1'b0;
    logic       p_en = 1'b0;
    logic       p_valid = 1'b0;
    logic [7:0] p_data = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard and hold-stability monitor on dut1
    always @(negedge clk) begin
        if (!rst_n) begin
            p_hold  = 1'b0;
            p_valid = 1'b0;
        end else begin
            if (p_hold && p_en) begin
                total++;
                if (!out_valid || out_data !== p_data) begin
                    bad++;
                    $display("FAIL hold_stable: got valid=%0b data=%02h, expected valid=1 data=%02h",
                             out_valid, out_data, p_data);
                end
            end
            if (out_valid && !p_valid && rise_cyc < 0) rise_cyc = cyc;
            if (out_valid && out_ready) begin
                total++;
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_word: got data=%02h, expected no word", out_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        bad++;
                        $display("FAIL word_data: got %02h, expected %02h", out_data, e);
                    end
                end
            end
            p_hold  = out_valid && !out_ready;
            p_data  = out_data;
            p_en    = en;
            p_valid = out_valid;
        end
    end

    // Filler keeps the sampled stream in aligned 00/11 pairs: no emitted
    // bits and no long runs.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 rnd_raw = ph[1];
            ph++;
        end
    endtask

    // Clears the datapath with en low, then drives one sample per clock
    // (MSB of bits[n-1:0] first) with en rising so that the first strobe
    // lands on the first sample.
    task automatic run_bits(input logic [63:0] bits, input int n);
        @(posedge clk);
        #1 en = 1'b0;
        rnd_raw = 1'b0;
        @(posedge clk);
        #1;
        c0 = cyc;
        rise_cyc = -1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            rnd_raw = bits[n-1-i];
            if (i == 2) en = 1'b1;
        end
        ph = 0;
    endtask

    initial begin
        int sc;
        int first_s;
        int nv;

        vt[0] = '{64'h9A59,     16, 1, 8'hB2, 8'h00, 18};
        vt[1] = '{64'h86E46D,   24, 1, 8'hB2, 8'h00, 26};
        vt[2] = '{64'hAAAA,     16, 1, 8'hFF, 8'h00, 18};
        vt[3] = '{64'h5555,     16, 1, 8'h00, 8'h00, 18};
        vt[4] = '{64'h6699A55A, 32, 2, 8'h5A, 8'hC3, 18};
        vt[5] = '{64'h2AAA,     14, 0, 8'h00, 8'h00, -1};

        rst_n = 1'b0;
        en = 1'b0;
        rnd_raw = 1'b0;
        out_ready = 1'b1;
        en4 = 1'b0;
        raw4 = 1'b0;
        ready4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, out_valid}, 0);
        chk("reset_data", {24'd0, out_data}, 0);
        chk("reset_health", {31'd0, health_fail}, 0);
        chk("reset_bitcnt", {28'd0, dut1.bit_cnt}, 0);
        rst_n = 1'b1;

        // Table-driven packing vectors with out_ready held high
        for (int v = 0; v < 6; v++) begin
            acc_cnt = 0;
            if (vt[v].nw > 0) exp_q.push_back(vt[v].w0);
            if (vt[v].nw > 1) exp_q.push_back(vt[v].w1);
            run_bits(vt[v].bits, vt[v].n);
            idle(30);
            chk($sformatf("vec%0d_words", v), acc_cnt, vt[v].nw);
            chk($sformatf("vec%0d_latency", v), (rise_cyc < 0) ? -1 : rise_cyc - c0, vt[v].rise);
            chk($sformatf("vec%0d_queue", v), exp_q.size(), 0);
        end

        // Backpressure: two words plus four extra bits with out_ready low
        out_ready = 1'b0;
        acc_cnt = 0;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hC3);
        run_bits(64'h6699A55AAA, 40);
        idle(20);
        chk("bp_valid1", {31'd0, out_valid}, 1);
        chk("bp_data1", {24'd0, out_data}, 32'h5A);
        chk("bp_bitcnt_full", {28'd0, dut1.bit_cnt}, 8);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("bp_accept1", acc_cnt, 1);
        chk("bp_valid2", {31'd0, out_valid}, 1);
        chk("bp_data2", {24'd0, out_data}, 32'hC3);
        idle(10);
        chk("bp_data2_hold", {24'd0, out_data}, 32'hC3);
        chk("bp_extra_dropped", {28'd0, dut1.bit_cnt}, 0);
        out_ready = 1'b1;
        idle(10);
        chk("bp_accept2", acc_cnt, 2);
        chk("bp_drained", {31'd0, out_valid}, 0);
        chk("bp_queue", exp_q.size(), 0);

        // en low with a word pending and five bits in the shift register
        out_ready = 1'b0;
        run_bits({38'd0, 16'h9A59, 10'h269}, 26);
        idle(8);
        chk("mid_valid", {31'd0, out_valid}, 1);
        chk("mid_data", {24'd0, out_data}, 32'hB2);
        chk("mid_bitcnt", {28'd0, dut1.bit_cnt}, 5);
        en = 1'b0;
        idle(1);
        chk("en_low_valid", {31'd0, out_valid}, 0);
        chk("en_low_bitcnt", {28'd0, dut1.bit_cnt}, 0);
        out_ready = 1'b1;

        // Repetition-count health test: 32 identical strobes
        @(posedge clk);
        #1 en = 1'b0;
        rnd_raw = 1'b1;
        repeat (3) @(posedge clk);
        #1 en = 1'b1;
        repeat (31) @(posedge clk);
        @(negedge clk);
        chk("health_31", {31'd0, health_fail}, 0);
        @(posedge clk);
        @(negedge clk);
        chk("health_32", {31'd0, health_fail}, {31'd0, HEALTH_ON});
`ifdef TRNG_HEALTH_EN
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 rnd_raw = ~rnd_raw;
            @(negedge clk);
            if (out_valid) nv++;
        end
        chk("health_blocks_words", nv, 0);
        chk("health_sticky", {31'd0, health_fail}, 1);
`endif
        @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        #1;
        chk("health_clear", {31'd0, health_fail}, 0);

        // Divider on dut4: rnd_raw toggles every clock
        @(posedge clk);
        #1 en4 = 1'b1;
        sc = 0;
        first_s = -1;
        nv = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (dut4.strobe) begin
                sc++;
                if (first_s < 0) first_s = i;
            end
            if (valid4) nv++;
            @(posedge clk);
            #1 raw4 = ~raw4;
        end
        en4 = 1'b0;
        chk("div_strobes", sc, 400 / 4);
        chk("div_first_strobe", first_s, 4);
        chk("div_no_words", nv, 0);

        // Asynchronous reset with a word held
        out_ready = 1'b0;
        run_bits(64'h9A59, 16);
        idle(6);
        chk("arst_pre_valid", {31'd0, out_valid}, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 0);
        chk("arst_data", {24'd0, out_data}, 0);
        chk("arst_health", {31'd0, health_fail}, 0);
        #10 rst_n = 1'b1;
        #10;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
